// File: rtl/mgt_01_pkg.sv
// Shared MicroGT-01 definitions.
// Default square-root widths and FSM state type.
package mgt_01_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int OUT_WIDTH_DEF  = DATA_WIDTH_DEF / 2;

    typedef enum logic [1:0] {
        LOAD,
        ITER,
        DONE
    } nr_sqrt_state_t;

endpackage

// File: rtl/mgt_01_nr_sqrt_step.sv
// One non-restoring square-root step.
// Consumes a radicand bit pair, yields next remainder and root.
module mgt_01_nr_sqrt_step #(
    parameter int OUT_WIDTH = 12
) (
    input  logic [OUT_WIDTH+1:0] r,
    input  logic [OUT_WIDTH-1:0] q,
    input  logic [1:0]           pair,
    output logic [OUT_WIDTH+1:0] r_next,
    output logic [OUT_WIDTH-1:0] q_next
);

    logic [OUT_WIDTH+1:0] p;

    assign p = {r[OUT_WIDTH-1:0], pair};

    // Subtract trial root when remainder is non-negative, else add back.
    always_comb begin
        r_next = '0;
        if (r[OUT_WIDTH+1]) begin
            r_next = p + {q, 2'b11};
        end else begin
            r_next = p - {q, 2'b01};
        end
        q_next = {q[OUT_WIDTH-2:0], ~r_next[OUT_WIDTH+1]};
    end

endmodule

// File: rtl/mgt_01_nr_sqrt.sv
// Free-running iterative non-restoring integer square root.
// One root bit per enabled cycle; result pulses valid_o every OUT_WIDTH+2 cycles.
module mgt_01_nr_sqrt
    import mgt_01_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = DATA_WIDTH / 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] radicand_i,
    output logic [OUT_WIDTH-1:0]  root_o,
    output logic [OUT_WIDTH-1:0]  remainder_o,
    output logic                  valid_o
);

    localparam int RW = OUT_WIDTH + 2;
    localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    nr_sqrt_state_t        state;
    logic [DATA_WIDTH-1:0] d;
    logic [RW-1:0]         r;
    logic [OUT_WIDTH-1:0]  q;
    logic [CW-1:0]         cnt;

    logic [1:0]            pair;
    logic [RW-1:0]         r_next;
    logic [OUT_WIDTH-1:0]  q_next;
    logic [RW-1:0]         r_fix;

    // Select radicand bit pair {d[2i+1], d[2i]} for the current step.
    assign pair = 2'(d >> {cnt, 1'b0});

    // Final correction: a negative remainder gets {Q,1} added back.
    assign r_fix = r[RW-1] ? (r + {1'b0, q, 1'b1}) : r;

    mgt_01_nr_sqrt_step #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_step (
        .r      (r),
        .q      (q),
        .pair   (pair),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Sequencer: LOAD -> ITER x OUT_WIDTH -> DONE, frozen when clk_en_i is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= LOAD;
            d           <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            root_o      <= '0;
            remainder_o <= '0;
            valid_o     <= 1'b0;
        end else if (clk_en_i) begin
            unique case (state)
                LOAD: begin
                    d       <= radicand_i;
                    r       <= '0;
                    q       <= '0;
                    cnt     <= CW'(OUT_WIDTH - 1);
                    valid_o <= 1'b0;
                    state   <= ITER;
                end
                ITER: begin
                    r <= r_next;
                    q <= q_next;
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    r           <= r_fix;
                    root_o      <= q;
                    remainder_o <= r_fix[OUT_WIDTH-1:0];
                    valid_o     <= 1'b1;
                    state       <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mgt_01_nr_sqrt.sv
// Randomized self-checking bench for mgt_01_nr_sqrt.
// Reference root found by plain integer search, not by bit iteration.
module tb_mgt_01_nr_sqrt;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic [23:0] radicand;
    logic [11:0] root;
    logic [11:0] rem;
    logic        valid;

    int vectors     = 0;
    int miscompares = 0;

    longint exp_root = 0;
    longint exp_rem  = 0;

    mgt_01_nr_sqrt dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .clk_en_i    (clk_en),
        .radicand_i  (radicand),
        .root_o      (root),
        .remainder_o (rem),
        .valid_o     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint ref_root(input longint x);
        longint s = 0;
        while ((s + 1) * (s + 1) <= x) s++;
        return s;
    endfunction

    function automatic longint ref_rem(input longint x);
        longint s = ref_root(x);
        return (x - s * s) % 4096;
    endfunction

    // One full period of 14 enabled edges; first edge is the LOAD sample.
    task automatic run_txn(input logic [23:0] x, input int chg_at,
                           input logic [23:0] x2, input int stall_at,
                           input int stall_len);
        radicand = x;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 14) begin
                exp_root = ref_root(longint'(x));
                exp_rem  = ref_rem(longint'(x));
            end
            chk("valid", longint'(valid), longint'(k == 14));
            chk("root", longint'(root), exp_root);
            chk("rem", longint'(rem), exp_rem);
            if (k == chg_at) radicand = x2;
            if (k == stall_at) begin
                clk_en = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", longint'(valid), longint'(k == 14));
                    chk("stall_root", longint'(root), exp_root);
                    chk("stall_rem", longint'(rem), exp_rem);
                end
                clk_en = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] x;
        logic [23:0] x2;
        logic [23:0] pend;
        bit          use_pend;

        rst_n    = 1'b1;
        clk_en   = 1'b1;
        radicand = 24'd4;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", longint'(valid), 0);
        chk("rst_root", longint'(root), 0);
        chk("rst_rem", longint'(rem), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(24'd4, 0, 24'd0, 0, 0);
        run_txn(24'd4, 0, 24'd0, 0, 0);
        run_txn(24'd16, 0, 24'd0, 0, 0);
        run_txn(24'd35, 0, 24'd0, 0, 0);
        run_txn(24'd0, 0, 24'd0, 0, 0);
        run_txn(24'hFFFFF0, 0, 24'd0, 0, 0);
        run_txn(24'd1, 0, 24'd0, 0, 0);
        run_txn(24'hFFFFFF, 0, 24'd0, 0, 0);

        // Input change during ITER is ignored, then picked up next LOAD.
        run_txn(24'd35, 4, 24'd10000, 0, 0);
        run_txn(24'd10000, 0, 24'd0, 0, 0);

        // Enable drop mid-ITER, and while valid is high.
        run_txn(24'd123456, 0, 24'd0, 6, 5);
        run_txn(24'd999, 0, 24'd0, 14, 3);

        // Asynchronous reset mid-ITER.
        run_txn(24'hFFFFF0, 0, 24'd0, 0, 0);
        radicand = 24'd35;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        exp_root = 0;
        exp_rem  = 0;
        chk("arst_valid", longint'(valid), 0);
        chk("arst_root", longint'(root), 0);
        chk("arst_rem", longint'(rem), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(24'd35, 0, 24'd0, 0, 0);

        use_pend = 1'b0;
        pend     = '0;
        for (int n = 0; n < 24; n++) begin
            x  = use_pend ? pend : 24'($urandom);
            x2 = 24'($urandom);
            use_pend = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                run_txn(x, int'($urandom_range(2, 13)), x2,
                        int'($urandom_range(1, 20)),
                        int'($urandom_range(1, 4)));
                pend     = x2;
                use_pend = 1'b1;
            end else begin
                run_txn(x, 0, x2, int'($urandom_range(1, 20)),
                        int'($urandom_range(1, 4)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
